// File: rtl/synaptic_update_ctrl_pkg.sv
// synaptic_update_ctrl_pkg: shared state encoding, sizing constants and helpers for the synaptic update sweep.
package synaptic_update_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_FETCH,
        S_READ,
        S_CALC,
        S_WRITE,
        S_FINISH
    } state_t;

    localparam int DEF_INPUT_NEURON       = 784;
    localparam int DEF_OUTPUT_NEURON      = 256;
    localparam int DEF_POST_NEUR_PARALLEL = 4;
    localparam int CYCLES_PER_WORD        = 3;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int words(input int out_n, input int par);
        return out_n / par;
    endfunction

    localparam int DEF_WORDS       = words(DEF_OUTPUT_NEURON, DEF_POST_NEUR_PARALLEL);
    localparam int DEF_PRE_CNT_W   = cnt_width(DEF_INPUT_NEURON);
    localparam int DEF_WORD_CNT_W  = cnt_width(DEF_WORDS);
    localparam int DEF_ADDR_CNT_W  = cnt_width(DEF_INPUT_NEURON * DEF_WORDS);

endpackage

// File: rtl/synaptic_update_ctrl_if.sv
// synaptic_update_ctrl_if: request inputs and SRAM/update-logic strobes of the synaptic update controller.
interface synaptic_update_ctrl_if #(
    parameter int PRE_NEUR_ADDR_WIDTH   = 10,
    parameter int POST_NEUR_ADDR_WIDTH  = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH  = 16,
    parameter int GRAD_ARRAY_ADDR_WIDTH = 16
);
    logic                             start;
    logic                             is_train;
    logic                             pre_neur_cs;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]   pre_neuron_address;
    logic [POST_NEUR_ADDR_WIDTH-1:0]  post_neuron_address;
    logic                             syn_cs;
    logic                             syn_we;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0]  syn_array_addr;
    logic                             grad_cs;
    logic                             grad_we;
    logic [GRAD_ARRAY_ADDR_WIDTH-1:0] grad_array_addr;
    logic                             tref_event;
    logic                             busy;
    logic                             done;

    modport master (
        input  start, is_train,
        output pre_neur_cs, pre_neuron_address, post_neuron_address,
               syn_cs, syn_we, syn_array_addr, grad_cs, grad_we, grad_array_addr,
               tref_event, busy, done
    );

    modport slave (
        output start, is_train,
        input  pre_neur_cs, pre_neuron_address, post_neuron_address,
               syn_cs, syn_we, syn_array_addr, grad_cs, grad_we, grad_array_addr,
               tref_event, busy, done
    );
endinterface

// File: rtl/synaptic_update_ctrl.sv
// synaptic_update_ctrl: sweeps weight/gradient SRAM words with a read/calc/write-back sequence per word.
module synaptic_update_ctrl
    import synaptic_update_ctrl_pkg::*;
#(
    parameter int INPUT_NEURON          = DEF_INPUT_NEURON,
    parameter int OUTPUT_NEURON         = DEF_OUTPUT_NEURON,
    parameter int POST_NEUR_PARALLEL    = DEF_POST_NEUR_PARALLEL,
    parameter int PRE_NEUR_ADDR_WIDTH   = 10,
    parameter int POST_NEUR_ADDR_WIDTH  = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH  = 16,
    parameter int GRAD_ARRAY_ADDR_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    synaptic_update_ctrl_if.master bus
);
    localparam int N_WORDS = words(OUTPUT_NEURON, POST_NEUR_PARALLEL);
    localparam int PRE_W   = cnt_width(INPUT_NEURON);
    localparam int WORD_W  = cnt_width(N_WORDS);
    localparam int ADDR_W  = cnt_width(INPUT_NEURON * N_WORDS);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(INPUT_NEURON - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(N_WORDS - 1);

    state_t              state, state_n;
    logic [PRE_W-1:0]    pre_idx, pre_n;
    logic [WORD_W-1:0]   word_idx, word_n;
    logic [ADDR_W-1:0]   addr, addr_n;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= S_IDLE;
            pre_idx  <= '0;
            word_idx <= '0;
            addr     <= '0;
        end else begin
            state    <= state_n;
            pre_idx  <= pre_n;
            word_idx <= word_n;
            addr     <= addr_n;
        end

    // addr is a running word counter, so pre_idx*N_WORDS+word_idx needs no multiplier
    always_comb begin
        state_n = state;
        pre_n   = pre_idx;
        word_n  = word_idx;
        addr_n  = addr;
        case (state)
            S_IDLE:      if (bus.start) state_n = bus.is_train ? S_PRE_FETCH : S_FINISH;
            S_PRE_FETCH: state_n = S_READ;
            S_READ:      state_n = S_CALC;
            S_CALC:      state_n = S_WRITE;
            S_WRITE:
                if (word_idx != WORD_LAST) begin
                    word_n  = word_idx + 1'b1;
                    addr_n  = addr + 1'b1;
                    state_n = S_READ;
                end else if (pre_idx != PRE_LAST) begin
                    word_n  = '0;
                    pre_n   = pre_idx + 1'b1;
                    addr_n  = addr + 1'b1;
                    state_n = S_PRE_FETCH;
                end else
                    state_n = S_FINISH;
            S_FINISH: begin
                pre_n   = '0;
                word_n  = '0;
                addr_n  = '0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.pre_neur_cs         = state == S_PRE_FETCH;
    assign bus.syn_cs              = state == S_READ || state == S_WRITE;
    assign bus.syn_we              = state == S_WRITE;
    assign bus.grad_cs             = bus.syn_cs;
    assign bus.grad_we             = bus.syn_we;
    assign bus.tref_event          = state == S_CALC || state == S_WRITE;
    assign bus.busy                = state inside {S_PRE_FETCH, S_READ, S_CALC, S_WRITE};
    assign bus.done                = state == S_FINISH;
    assign bus.pre_neuron_address  = PRE_NEUR_ADDR_WIDTH'(pre_idx);
    assign bus.post_neuron_address = POST_NEUR_ADDR_WIDTH'(word_idx) * POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);
    assign bus.syn_array_addr      = SYN_ARRAY_ADDR_WIDTH'(addr);
    assign bus.grad_array_addr     = GRAD_ARRAY_ADDR_WIDTH'(addr);

endmodule

// File: tb/tb_synaptic_update_ctrl.sv
// tb_synaptic_update_ctrl: randomized bench comparing every cycle against a loop-built expected event stream.
module tb_synaptic_update_ctrl;
    import synaptic_update_ctrl_pkg::*;

    localparam int IN  = 4;
    localparam int OUT = 8;
    localparam int PAR = 4;
    localparam int W   = OUT / PAR;
    localparam int SWEEP_DONE = IN * (1 + CYCLES_PER_WORD * W) + 1;

    typedef struct packed {
        logic        pre_cs;
        logic [9:0]  pre_addr;
        logic [9:0]  post_addr;
        logic        syn_cs;
        logic        syn_we;
        logic        grad_cs;
        logic        grad_we;
        logic [15:0] syn_addr;
        logic [15:0] grad_addr;
        logic        tref;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct packed {
        obs_t v;
        logic cp;
        logic cw;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    logic mem_init = 0;
    int   vectors = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [15:0] wmem [0:7];
    logic [15:0] gmem [0:7];
    logic [15:0] rd_w, rd_g;

    synaptic_update_ctrl_if #(
        .PRE_NEUR_ADDR_WIDTH(10), .POST_NEUR_ADDR_WIDTH(10),
        .SYN_ARRAY_ADDR_WIDTH(16), .GRAD_ARRAY_ADDR_WIDTH(16)
    ) bus ();

    synaptic_update_ctrl #(
        .INPUT_NEURON(IN), .OUTPUT_NEURON(OUT), .POST_NEUR_PARALLEL(PAR),
        .PRE_NEUR_ADDR_WIDTH(10), .POST_NEUR_ADDR_WIDTH(10),
        .SYN_ARRAY_ADDR_WIDTH(16), .GRAD_ARRAY_ADDR_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic pcs, input int pre, input int post, input logic cs,
                                input logic we, input int a, input logic tref, input logic busy,
                                input logic done, input logic cp, input logic cw);
        exp_t e;
        e.v.pre_cs    = pcs;
        e.v.pre_addr  = 10'(pre);
        e.v.post_addr = 10'(post);
        e.v.syn_cs    = cs;
        e.v.syn_we    = we;
        e.v.grad_cs   = cs;
        e.v.grad_we   = we;
        e.v.syn_addr  = 16'(a);
        e.v.grad_addr = 16'(a);
        e.v.tref      = tref;
        e.v.busy      = busy;
        e.v.done      = done;
        e.cp          = cp;
        e.cw          = cw;
        return e;
    endfunction

    function automatic obs_t msk(input obs_t o, input logic cp, input logic cw);
        obs_t r = o;
        if (!cp) r.pre_addr = '0;
        if (!cw) begin
            r.post_addr = '0;
            r.syn_addr  = '0;
            r.grad_addr = '0;
        end
        return r;
    endfunction

    function automatic obs_t cur_obs();
        obs_t o;
        o.pre_cs    = bus.pre_neur_cs;
        o.pre_addr  = bus.pre_neuron_address;
        o.post_addr = bus.post_neuron_address;
        o.syn_cs    = bus.syn_cs;
        o.syn_we    = bus.syn_we;
        o.grad_cs   = bus.grad_cs;
        o.grad_we   = bus.grad_we;
        o.syn_addr  = bus.syn_array_addr;
        o.grad_addr = bus.grad_array_addr;
        o.tref      = bus.tref_event;
        o.busy      = bus.busy;
        o.done      = bus.done;
        return o;
    endfunction

    // one fetch per pre index, then read/calc/write per word, then a single finish cycle
    task automatic push_sweep();
        for (int p = 0; p < IN; p++) begin
            exp_q.push_back(mk(1, p, 0, 0, 0, 0, 0, 1, 0, 1, 0));
            for (int w = 0; w < W; w++) begin
                exp_q.push_back(mk(0, p, w * PAR, 1, 0, p * W + w, 0, 1, 0, 1, 1));
                exp_q.push_back(mk(0, p, w * PAR, 0, 0, p * W + w, 1, 1, 0, 1, 1));
                exp_q.push_back(mk(0, p, w * PAR, 1, 1, p * W + w, 1, 1, 0, 1, 1));
            end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    endtask

    always @(posedge clk)
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                if (bus.start && bus.is_train) push_sweep();
                else if (bus.start) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            end else
                void'(exp_q.pop_front());
        end

    always @(negedge rst_n) exp_q.delete();

    always @(negedge clk) begin
        exp_t e;
        e = (exp_q.size() != 0) ? exp_q[0] : mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("cycle", msk(cur_obs(), e.cp, e.cw), msk(e.v, e.cp, e.cw));
        check("we_implies_cs", {bus.syn_we & ~bus.syn_cs, bus.grad_we & ~bus.grad_cs}, 0);
    end

    always @(posedge clk)
        if (mem_init) begin
            for (int k = 0; k < 8; k++) begin
                wmem[k] <= 16'(k);
                gmem[k] <= 16'(k);
            end
        end else begin
            if (bus.syn_cs && !bus.syn_we) rd_w <= wmem[bus.syn_array_addr[2:0]];
            if (bus.syn_cs && bus.syn_we) wmem[bus.syn_array_addr[2:0]] <= rd_w + 16'd1;
            if (bus.grad_cs && !bus.grad_we) rd_g <= gmem[bus.grad_array_addr[2:0]];
            if (bus.grad_cs && bus.grad_we) gmem[bus.grad_array_addr[2:0]] <= rd_g + 16'd1;
        end

    task automatic sweep(input logic train, input logic repulse, output int first_pre,
                         output int last_done, output int ndone, output int ncs, output int first_addr);
        first_pre = -1;
        last_done = -1;
        ndone = 0;
        ncs = 0;
        first_addr = -1;
        bus.start = 1;
        bus.is_train = train;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            bus.start = repulse && (i == 5 || i == 12);
            bus.is_train = 1'($urandom);
            if (bus.pre_neur_cs && first_pre < 0) first_pre = i;
            if (bus.syn_cs && first_addr < 0) first_addr = int'(bus.syn_array_addr);
            ncs += int'(bus.pre_neur_cs | bus.syn_cs | bus.grad_cs | bus.syn_we | bus.grad_we);
            if (bus.done) begin
                ndone++;
                last_done = i;
            end
        end
        bus.start = 0;
    endtask

    initial begin
        int fp, ld, nd, nc, fa;
        bit found;
        bus.start = 0;
        bus.is_train = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_outputs", cur_obs(), 0);
        #1 rst_n = 1;
        @(negedge clk);
        mem_init = 1;
        @(negedge clk);
        mem_init = 0;

        sweep(1, 0, fp, ld, nd, nc, fa);
        check("s1_first_prefetch", fp, 1);
        check("s1_done_cycle", ld, SWEEP_DONE);
        check("s1_done_count", nd, 1);
        check("s1_first_addr", fa, 0);
        for (int k = 0; k < 8; k++) begin
            check("s1_weight", wmem[k], k + 1);
            check("s1_grad", gmem[k], k + 1);
        end

        sweep(0, 0, fp, ld, nd, nc, fa);
        check("s2_done_cycle", ld, 1);
        check("s2_done_count", nd, 1);
        check("s2_no_strobes", nc, 0);

        sweep(1, 1, fp, ld, nd, nc, fa);
        check("s4_done_cycle", ld, SWEEP_DONE);
        check("s4_done_count", nd, 1);

        bus.start = 1;
        bus.is_train = 1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            bus.start = 0;
            found = bus.syn_we && bus.syn_array_addr == 16'd3;
        end
        check("s5_reach_write3", found, 1);
        #1 rst_n = 0;
        #1 check("s5_async_clear", cur_obs(), 0);
        check("s5_busy", bus.busy, 0);
        @(negedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        sweep(1, 0, fp, ld, nd, nc, fa);
        check("s5_restart_addr", fa, 0);
        check("s5_restart_pre", fp, 1);
        check("s5_done_cycle", ld, SWEEP_DONE);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.start = $urandom_range(0, 9) == 0;
            bus.is_train = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 0;
                @(negedge clk);
                #1 rst_n = 1;
            end
        end
        bus.start = 0;
        repeat (40) @(negedge clk);
        check("drain_idle", bus.busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/synaptic_update_ctrl.md
Name: synaptic_update_ctrl

Overview:
Initiator side of the synaptic-core SRAM control interface. After each training sample it sweeps the whole weight and gradient arrays, one word of POST_NEUR_PARALLEL synapses at a time. For each word it runs a read / compute / write-back sequence, so the downstream FF-STDP update logic can rewrite weights and gradients in place. It also fetches the matching pre-neuron spike count and presents the post-neuron group address.

Parameters:
INPUT_NEURON, 784, number of pre-synaptic neurons (outer loop count)
OUTPUT_NEURON, 256, number of post-synaptic neurons
POST_NEUR_PARALLEL, 4, synapses per SRAM word
PRE_NEUR_ADDR_WIDTH, 10, pre-neuron address width
POST_NEUR_ADDR_WIDTH, 10, post-neuron address width
SYN_ARRAY_ADDR_WIDTH, 16, weight SRAM address width
GRAD_ARRAY_ADDR_WIDTH, 16, gradient SRAM address width

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
START  in  1  single-cycle request to begin a sweep
IS_TRAIN  in  1  sampled at START; 0 means no sweep, just a DONE pulse
CTRL_PRE_NEUR_CS  out  1  read strobe to the pre-neuron spike-count memory
CTRL_PRE_NEURON_ADDRESS  out  PRE_NEUR_ADDR_WIDTH  current pre index
CTRL_POST_NEURON_ADDRESS  out  POST_NEUR_ADDR_WIDTH  first post neuron of the current word (word*POST_NEUR_PARALLEL)
CTRL_SYNARRAY_CS / CTRL_SYNARRAY_WE  out  1 each  weight SRAM chip select / write enable
CTRL_SYNARRAY_ADDR  out  SYN_ARRAY_ADDR_WIDTH  weight word address
CTRL_GRAD_ARRAY_CS / CTRL_GRAD_ARRAY_WE  out  1 each  gradient SRAM chip select / write enable
CTRL_GRAD_ARRAY_ADDR  out  GRAD_ARRAY_ADDR_WIDTH  gradient word address, always equal to the weight address
CTRL_TREF_EVENT  out  1  update-active strobe to the FF-STDP update logic
BUSY  out  1  high from the cycle after START until DONE
DONE  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset: FSM goes to IDLE; all counters are 0; every output is 0.
- Derived constants:
  - WORDS = OUTPUT_NEURON/POST_NEUR_PARALLEL.
  - Word address = pre_idx*WORDS + word_idx, built with a running accumulator (+1 per word), not a multiplier.
- FSM states: IDLE, PRE_FETCH, READ, CALC, WRITE, FINISH.
- IDLE:
  - START & IS_TRAIN: go to PRE_FETCH with pre_idx=0, word_idx=0, addr=0, BUSY=1.
  - START & !IS_TRAIN: go to FINISH.
  - Otherwise stay in IDLE.
- PRE_FETCH (1 cycle):
  - CTRL_PRE_NEUR_CS=1 with CTRL_PRE_NEURON_ADDRESS=pre_idx.
  - The count is valid from the next cycle and is held by the memory until the next PRE_FETCH.
  - Next state: READ.
- READ (1 cycle):
  - SYN CS=1, WE=0; GRAD CS=1, WE=0.
  - ADDR=addr; CTRL_POST_NEURON_ADDRESS = word_idx*POST_NEUR_PARALLEL.
  - Next state: CALC.
- CALC (1 cycle):
  - Both CS=0; RDATA is now valid at the update logic.
  - CTRL_TREF_EVENT=1; addresses held.
  - Next state: WRITE.
- WRITE (1 cycle):
  - Both CS=1, WE=1, same address; CTRL_TREF_EVENT=1.
  - Then advance:
    - word_idx<WORDS-1: word_idx+1, addr+1, go to READ.
    - else pre_idx<INPUT_NEURON-1: word_idx=0, pre_idx+1, addr+1, go to PRE_FETCH.
    - else: go to FINISH.
- FINISH (1 cycle): DONE=1, BUSY=0, counters cleared; return to IDLE.
- Timing: per-word cost is 3 cycles. A full sweep takes INPUT_NEURON*(1+3*WORDS) cycles from the first PRE_FETCH, plus 1 FINISH cycle. The last address is INPUT_NEURON*WORDS-1; addr never wraps.
- START while BUSY is ignored; the sweep is not restarted.
- Reads and writes to the same address are never adjacent without a CALC cycle between them. WE is never asserted with CS low.
- IS_TRAIN changing mid-sweep has no effect; it is sampled only at START.
- Reset mid-sweep: immediate return to IDLE, all strobes low on reset assertion. No partial write is issued after reset.
- Address widths are zero-extended from the counters; the counter widths are $clog2 of their bounds.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE..FINISH, 3 bits).
  - WORDS, plus the pre, word and address counter width constants.
  - The per-word cycle cost constant (3).
- No sub-module is natural; one FSM with three counters (pre_idx, word_idx, addr accumulator).

Test Plan:
1. Small config INPUT_NEURON=4, OUTPUT_NEURON=8, POST_NEUR_PARALLEL=4 (WORDS=2); START with IS_TRAIN=1:
   - Address sequence 0..7, each read then written exactly once.
   - Post addresses alternate 0,4; DONE arrives 29 cycles after the START edge.
2. START with IS_TRAIN=0 -> DONE pulses on the next cycle; CS, WE and PRE_NEUR_CS never assert.
3. Scoreboard: SRAM model preloaded with weight k at word k, update logic stubbed as w+1 -> after DONE, word k holds k+1 for all 8 words; gradient array updated the same way.
4. START re-pulsed at cycles 5 and 12 of a running sweep -> the sequence is identical to scenario 1 and exactly one DONE pulse occurs.
5. RST_N low during the WRITE of address 3 -> all outputs 0 asynchronously, BUSY=0. A fresh START restarts at address 0 with pre_idx=0.
6. Protocol assertions over a random START/IS_TRAIN/reset run:
   - WE implies CS.
   - A READ of an address is followed by exactly one CALC and then a WRITE of the same address.
   - PRE_NEUR_CS precedes the first READ of every pre index.
